// File: rtl/apb_rr_master_arb.sv
// Round-robin arbiter feeding a single APB master sequencer.
// Each requester posts one read/write; the block runs SETUP/ACCESS and reports done/err/rdata.
module apb_rr_master_arb #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [DW-1:0]     rdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [AW-1:0]     paddr,
  output logic [DW-1:0]     pwdata,
  input  logic [DW-1:0]     prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [NREQ-1:0] r_done, w_done_nxt;
  logic            r_err, w_err_nxt;
  logic [DW-1:0]   r_rdata, w_rdata_nxt;
  logic            r_psel, w_psel_nxt;
  logic            r_penable, w_penable_nxt;
  logic            r_pwrite, w_pwrite_nxt;
  logic [AW-1:0]   r_paddr, w_paddr_nxt;
  logic [DW-1:0]   r_pwdata, w_pwdata_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [IW-1:0]   r_last, w_last_nxt;
  logic [IW-1:0]   r_owner, w_owner_nxt;

  logic [AW-1:0]   w_addr  [NREQ];
  logic [DW-1:0]   w_wdata [NREQ];
  logic [IW-1:0]   w_cand  [NREQ];
  logic [NREQ-1:0] w_hit;
  logic [IW-1:0]   w_winner;
  logic            w_any;

  // w_cand[gi] is the requester gi+1 places after the last owner.
  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_req
    assign w_addr[gi]  = req_addr[gi*AW +: AW];
    assign w_wdata[gi] = req_wdata[gi*DW +: DW];
    assign w_cand[gi]  = IW'((32'(r_last) + gi + 1) % NREQ);
    assign w_hit[gi]   = req[w_cand[gi]];
  end

  assign w_any = |req;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    w_winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_hit[k]) w_winner = w_cand[k];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_done_nxt    = r_done;
    w_err_nxt     = r_err;
    w_rdata_nxt   = r_rdata;
    w_psel_nxt    = r_psel;
    w_penable_nxt = r_penable;
    w_pwrite_nxt  = r_pwrite;
    w_paddr_nxt   = r_paddr;
    w_pwdata_nxt  = r_pwdata;
    w_cnt_nxt     = r_cnt;
    w_last_nxt    = r_last;
    w_owner_nxt   = r_owner;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_owner_nxt   = w_winner;
          w_gnt_nxt     = NREQ'(1) << w_winner;
          w_paddr_nxt   = w_addr[w_winner];
          w_pwdata_nxt  = w_wdata[w_winner];
          w_pwrite_nxt  = req_write[w_winner];
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_state_nxt   = S_SETUP;
        end
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
        w_state_nxt   = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          if (!r_pwrite) w_rdata_nxt = prdata;
          w_err_nxt     = pslverr;
          w_done_nxt    = r_gnt;
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_last_nxt    = r_owner;
          w_state_nxt   = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_err_nxt     = 1'b1;
          w_rdata_nxt   = '0;
          w_done_nxt    = r_gnt;
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_last_nxt    = r_owner;
          w_state_nxt   = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_done_nxt  = '0;
        w_gnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_cnt     <= '0;
      r_last    <= IDX_LAST;
      r_owner   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_rdata   <= w_rdata_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_paddr   <= w_paddr_nxt;
      r_pwdata  <= w_pwdata_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last    <= w_last_nxt;
      r_owner   <= w_owner_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign err     = r_err;
  assign rdata   = r_rdata;
  assign psel    = r_psel;
  assign penable = r_penable;
  assign pwrite  = r_pwrite;
  assign paddr   = r_paddr;
  assign pwdata  = r_pwdata;

endmodule

// File: tb/tb_apb_rr_master_arb.sv
// Bench for apb_rr_master_arb: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a round-robin/APB transaction model.
module tb_apb_rr_master_arb;
  localparam int NREQ = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;

  logic pclk = 1'b0;
  logic prst;
  logic [NREQ-1:0] req, req_write, gnt, done;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic err, psel, penable, pwrite, pready, pslverr;
  logic [DW-1:0] rdata, pwdata, prdata;
  logic [AW-1:0] paddr;

  int n_total = 0;
  int n_pass = 0;

  always #5 pclk = ~pclk;

  apb_rr_master_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .prst(prst), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .err(err), .rdata(rdata), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  typedef struct {
    int rq; logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata;
    int nwait; logic [DW-1:0] rd; logic serr;
    logic exp_err; logic [DW-1:0] exp_rdata; int exp_cyc;
  } vec_t;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0 && i < NREQ) v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin rule: first pending requester after the last owner, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] pend, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (last + k) % NREQ;
      if (pend[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_cmd(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = wd;
    req[i] = 1'b1;
  endtask

  task automatic wait_psel();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (psel !== 1'b1 && n < 4);
    check("grant_wait_psel", psel, 1'b1);
  endtask

  // Entered in SETUP; plays the slave and returns ACCESS cycles until done (-1 if none).
  task automatic do_xfer(input int nwait, input logic [DW-1:0] rd, input logic serr,
                         input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         output int cyc);
    logic ok;
    ok = (psel === 1'b1 && penable === 1'b0 && pwrite === wr && paddr === a && pwdata === wd);
    check("setup_phase", ok, 1'b1);
    pready = 1'b0;
    tick();
    cyc = -1;
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      if (!(psel === 1'b1 && penable === 1'b1 && paddr === a && pwrite === wr && pwdata === wd)) ok = 1'b0;
      pready = (i == nwait);
      prdata = rd;
      pslverr = serr;
      tick();
      if (done !== '0) begin
        cyc = i + 1;
        break;
      end
    end
    pready = 1'b0;
    pslverr = 1'b0;
    check("access_stable", ok, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs [8];
    vec_t r;
    int cyc, w, nwait, sel;
    logic [NREQ-1:0] pend;
    logic c_wr [NREQ];
    logic [AW-1:0] c_addr [NREQ];
    logic [DW-1:0] c_wd [NREQ];
    int m_last;
    logic [DW-1:0] m_rdata, rd;
    logic serr, exp_err;

    vecs[0] = '{0, 1'b1, 32'h4,  32'hA5,   0,  32'h7777_7777, 1'b0, 1'b0, 32'h0,         1};
    vecs[1] = '{2, 1'b0, 32'h8,  32'h0,    3,  32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 4};
    vecs[2] = '{1, 1'b1, 32'h1F, 32'h1234, 0,  32'h7777_7777, 1'b1, 1'b1, 32'hDEAD_BEEF, 1};
    vecs[3] = '{3, 1'b0, 32'h10, 32'h0,    99, 32'h55,        1'b0, 1'b1, 32'h0,         16};
    vecs[4] = '{0, 1'b0, 32'h20, 32'h0,    15, 32'hCAFE_F00D, 1'b0, 1'b0, 32'hCAFE_F00D, 16};
    vecs[5] = '{2, 1'b0, 32'h24, 32'h0,    1,  32'h1111_2222, 1'b1, 1'b1, 32'h1111_2222, 2};
    vecs[6] = '{1, 1'b1, 32'h30, 32'h9ABC, 2,  32'h7777_7777, 1'b0, 1'b0, 32'h1111_2222, 3};
    vecs[7] = '{3, 1'b1, 32'h3C, 32'h5A5A, 99, 32'h7777_7777, 1'b0, 1'b1, 32'h0,         16};

    prst = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick(); tick();
    check("reset_ctrl", {gnt, done, err, psel, penable, pwrite}, '0);
    check("reset_bus", {paddr, pwdata}, '0);
    check("reset_rdata", rdata, '0);
    prst = 1'b0;

    // Directed table: one requester at a time, exact latency.
    for (int v = 0; v < 8; v++) begin
      r = vecs[v];
      set_cmd(r.rq, r.wr, r.addr, r.wdata);
      tick();
      check("vec_psel_latency", {psel, penable}, 2'b10);
      check("vec_gnt", gnt, onehot(r.rq));
      req_addr = {$urandom(), $urandom(), $urandom(), $urandom()};
      req_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      req_write = NREQ'($urandom());
      do_xfer(r.nwait, r.rd, r.serr, r.wr, r.addr, r.wdata, cyc);
      req = '0;
      check("vec_cycles", cyc, r.exp_cyc);
      check("vec_done", done, onehot(r.rq));
      check("vec_err", err, r.exp_err);
      check("vec_rdata", rdata, r.exp_rdata);
      check("vec_done_bus", {psel, penable, gnt}, {2'b00, onehot(r.rq)});
      tick();
      check("vec_idle", {done, gnt}, '0);
      $display("vec %0d: req%0d %s addr=0x%0h cycles=%0d err=%0b rdata=0x%0h",
               v, r.rq, r.wr ? "WR" : "RD", r.addr, cyc, err, rdata);
    end

    // Fairness with all requesters held high from reset.
    prst = 1'b1; tick(); prst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b1, 32'h100 + 32'(i * 4), 32'(i));
    for (int g = 0; g < 6; g++) begin
      w = g % NREQ;
      wait_psel();
      check("fair_gnt", gnt, onehot(w));
      do_xfer(0, 32'h0, 1'b0, 1'b1, 32'h100 + 32'(w * 4), 32'(w), cyc);
      check("fair_one_done", {cyc, done}, {32'd1, onehot(w)});
      tick();
      check("fair_idle", {done, gnt}, '0);
      $display("fair %0d: granted req%0d", g, w);
    end

    // Reset during a wait-stated read, then requester 0 must win over 2.
    req = '0;
    set_cmd(2, 1'b0, 32'h8, 32'h0);
    wait_psel();
    check("rst_mid_gnt", gnt, onehot(2));
    pready = 1'b0;
    tick(); tick(); tick();
    check("rst_mid_access", {psel, penable}, 2'b11);
    prst = 1'b1;
    tick();
    check("rst_mid_drop", {psel, penable, gnt, done}, '0);
    prst = 1'b0;
    req = '0;
    set_cmd(0, 1'b0, 32'h40, 32'h0);
    set_cmd(2, 1'b0, 32'h8, 32'h0);
    wait_psel();
    check("rst_after_gnt", gnt, onehot(0));
    do_xfer(0, 32'h600D_600D, 1'b0, 1'b0, 32'h40, 32'h0, cyc);
    check("rst_after_done", {done, rdata}, {onehot(0), 32'h600D_600D});
    req = '0;
    tick();
    $display("reset-mid: req0 won after release, rdata=0x%0h", rdata);

    // Randomized traffic against the transaction model.
    prst = 1'b1; tick(); prst = 1'b0;
    pend = '0; m_last = NREQ - 1; m_rdata = '0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1 || (pend == '0 && i == NREQ - 1))) begin
          c_wr[i] = 1'($urandom()); c_addr[i] = $urandom(); c_wd[i] = $urandom();
          set_cmd(i, c_wr[i], c_addr[i], c_wd[i]);
          pend[i] = 1'b1;
        end
      end
      w = rr_pick(pend, m_last);
      wait_psel();
      check("rand_gnt", gnt, onehot(w));
      req_addr[w*AW +: AW] = $urandom();
      req_wdata[w*DW +: DW] = $urandom();
      sel = $urandom_range(0, 9);
      nwait = (sel < 7) ? $urandom_range(0, 4) : (sel == 7) ? TIMEOUT - 1 :
              (sel == 8) ? TIMEOUT : TIMEOUT + 3;
      serr = ($urandom_range(0, 7) == 0);
      rd = $urandom();
      do_xfer(nwait, rd, serr, c_wr[w], c_addr[w], c_wd[w], cyc);
      if (nwait >= TIMEOUT) begin
        exp_err = 1'b1;
        m_rdata = '0;
      end else begin
        exp_err = serr;
        if (!c_wr[w]) m_rdata = rd;
      end
      check("rand_cycles", cyc, (nwait < TIMEOUT) ? nwait + 1 : TIMEOUT);
      check("rand_done", done, onehot(w));
      check("rand_err", err, exp_err);
      check("rand_rdata", rdata, m_rdata);
      m_last = w;
      pend[w] = 1'b0;
      req[w] = 1'b0;
      tick();
      check("rand_idle", {done, gnt}, '0);
      $display("rand %0d: req%0d %s addr=0x%0h wait=%0d err=%0b rdata=0x%0h",
               t, w, c_wr[w] ? "WR" : "RD", c_addr[w], nwait, err, rdata);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/apb_rr_master_arb.md
Name: apb_rr_master_arb

Overview:
- Round-robin arbiter plus APB master sequencer: shares one APB bus between NREQ requesters.
- Each requester posts a single read or write command.
- The block arbitrates, drives APB SETUP/ACCESS phases, handles wait states, PSLVERR and timeout, and returns read data with a one-cycle done pulse.
- Sits between local command sources (CPU port, DMA, test driver) and the APB slave fabric.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort (>=1)

Ports:
- pclk  in  1  clock; all logic on rising edge
- prst  in  1  synchronous active-high reset
- req  in  NREQ  request per requester; held high until its done
- req_write  in  NREQ  1=write, 0=read, per requester
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data; same packing
- gnt  out  NREQ  one-hot current owner; zero when idle
- done  out  NREQ  one-cycle completion pulse to owner
- err  out  1  valid with done; 1 = PSLVERR or timeout
- rdata  out  DW  read data; valid with done, held until next done
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  AW  APB address
- pwdata  out  DW  APB write data
- prdata  in  DW  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

Behaviour:
- All outputs registered.
- Reset (sync, prst=1 at edge): state=IDLE; gnt, done, err, psel, penable, pwrite=0; paddr, pwdata, rdata=0; timeout counter=0; round-robin pointer last=NREQ-1, so requester 0 has top priority first.
- Reset mid-transfer: psel/penable drop at that edge; no done pulse; the aborted requester must re-request.
- FSM: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any req: winner = first set bit searching last+1, last+2, ... (mod NREQ).
  - Next edge: latch req_addr/req_wdata/req_write of the winner into paddr/pwdata/pwrite; gnt=onehot(winner); psel=1; penable=0; go SETUP.
  - No req: stay; bus outputs hold last values with psel=0.
- SETUP: exactly one cycle. Next edge: penable=1, counter=0, go ACCESS.
- ACCESS:
  - pready=1: next edge captures rdata=prdata (reads only; writes leave rdata unchanged), err=pslverr, done[winner]=1, psel=penable=0, last=winner, go DONE.
  - pready=0: counter increments. When counter==TIMEOUT-1 with pready still 0, next edge aborts: done[winner]=1, err=1, rdata=0, psel=penable=0, last=winner, go DONE.
  - pready=1 on the timeout cycle: normal completion wins.
- DONE: exactly one cycle.
  - done high, gnt still high.
  - req is not sampled; the requester must drop req (or present its next command) during this cycle.
  - Next edge: done=0, gnt=0, err holds, go IDLE.
- paddr/pwrite/pwdata are stable from SETUP through the end of ACCESS. Changes on req_* after grant are ignored.
- req dropped by the owner mid-transfer: ignored; transfer completes normally.
- Zero-wait latency: req seen at edge k; psel at k+1; penable at k+2; done at k+3. Minimum 4 cycles per transfer, plus 1 IDLE cycle.
- Non-owner requesters wait; no starvation. Worst-case wait is (NREQ-1) transfers.

Test Plan:
- Single write, zero wait: req[0]=1, write, addr=0x4, wdata=0xA5 -> psel rises at +1, penable at +2; pready=1 gives done[0] at +3, err=0; paddr=0x4, pwdata=0xA5 stable across SETUP/ACCESS.
- Read with 3 wait states: req[2] read addr=0x8; slave holds pready=0 for 3 ACCESS cycles, then returns prdata=0xDEADBEEF -> done[2] 3 cycles later than zero-wait; rdata=0xDEADBEEF; err=0.
- Fairness: req[0..3] all held high after reset, each re-requesting after its done -> grant order 0,1,2,3,0,1; gnt always one-hot; exactly one done per grant.
- Timeout: TIMEOUT=16, pready tied 0 -> after 16 ACCESS cycles, done with err=1, rdata=0, psel=0. Also pready=1 exactly on the 16th cycle -> normal completion, err=0.
- Slave error: write to addr=0x1F with pslverr=1 on the pready cycle -> done with err=1; next arbitration proceeds normally.
- Reset mid-ACCESS: prst=1 during a wait-stated read -> next edge psel=penable=gnt=0, no done. After release, requester 0 wins first.
